mix_mem_arbiter: RTL and testbench

Two-port arbiter that shares the single-port 4096 × 31-bit MIX core memory between the CPU (fetch/execute/store) and the I/O channel (block OUT/IN transfers to the UART side). It is a dual-mode scheduler:
- Normally the CPU has priority.
- A starvation guard bounds I/O wait.
- A locked I/O burst mode streams consecutive I/O words, with a bounded yield to the CPU.

It sits between the core/I/O units and the memory array.

---
 rtl/mix_pkg.sv | 26 ++
 rtl/mix_mem_arbiter_if.sv | 37 +++
 rtl/mix_mem_arbiter.sv | 121 ++++++++++++
 tb/tb_mix_mem_arbiter.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/mix_pkg.sv
// Shared types and sizes for the MIX core memory arbiter: word geometry,
// access owners, scheduler states and the read-return tag.
package mix_pkg;
  localparam int MIX_AW = 12;
  localparam int MIX_DW = 31;

  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_IO  = 1'b1
  } owner_e;

  typedef enum logic [1:0] {
    CPU_PRI  = 2'd0,
    IO_BURST = 2'd1,
    IO_YIELD = 2'd2
  } state_e;

  typedef struct packed {
    logic   vld;
    owner_e own;
  } rtag_t;

  function automatic logic [7:0] sat_inc(input logic [7:0] v, input logic [7:0] lim);
    return (v >= lim) ? lim : v + 8'd1;
  endfunction
endpackage

// File: rtl/mix_mem_arbiter_if.sv
// Request/response bundle between CPU, I/O channel, memory array and arbiter.
interface mix_mem_arbiter_if #(
  parameter int AW = mix_pkg::MIX_AW,
  parameter int DW = mix_pkg::MIX_DW
);
  logic          cpu_req, cpu_we, cpu_gnt, cpu_rvalid;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata, cpu_rdata;

  logic          io_req, io_we, io_lock, io_gnt, io_rvalid;
  logic [AW-1:0] io_addr;
  logic [DW-1:0] io_wdata, io_rdata;

  logic [AW-1:0] mem_addr;
  logic          mem_we;
  logic [DW-1:0] mem_wdata, mem_rdata;

  // Requesters plus the memory array
  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output io_req, io_we, io_lock, io_addr, io_wdata,
    output mem_rdata,
    input  cpu_gnt, cpu_rvalid, cpu_rdata,
    input  io_gnt, io_rvalid, io_rdata,
    input  mem_addr, mem_we, mem_wdata
  );

  // Arbiter side
  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  io_req, io_we, io_lock, io_addr, io_wdata,
    input  mem_rdata,
    output cpu_gnt, cpu_rvalid, cpu_rdata,
    output io_gnt, io_rvalid, io_rdata,
    output mem_addr, mem_we, mem_wdata
  );
endinterface

// File: rtl/mix_mem_arbiter.sv
// Shares the single-port MIX core memory between CPU and I/O channel: CPU
// priority with a starvation guard, plus a locked I/O burst with bounded CPU yield.
module mix_mem_arbiter
  import mix_pkg::*;
#(
  parameter int AW     = MIX_AW,
  parameter int DW     = MIX_DW,
  parameter int STARVE = 4,
  parameter int BURST  = 8
) (
  input  logic            clk,
  input  logic            nreset,
  mix_mem_arbiter_if.slave bus
);

  localparam logic [3:0] STARVE_C = 4'(STARVE);
  localparam logic [7:0] BURST_C  = 8'(BURST);

  state_e        state_q, state_d;
  logic [3:0]    starve_q, starve_d;
  logic [7:0]    burst_q, burst_d, burst_inc;
  rtag_t         tag_q, tag_d;
  logic          cpu_gnt, io_gnt;
  logic [AW-1:0] maddr;
  logic [DW-1:0] mwdata;

  // Grants are combinational and forced off while reset is held
  always_comb begin
    cpu_gnt = 1'b0;
    io_gnt  = 1'b0;
    if (nreset) begin
      case (state_q)
        CPU_PRI: begin
          if (bus.io_req && (!bus.cpu_req || starve_q == STARVE_C)) io_gnt = 1'b1;
          else                                                    cpu_gnt = bus.cpu_req;
        end
        IO_BURST: begin
          io_gnt  = bus.io_req;
          cpu_gnt = bus.cpu_req & ~bus.io_req;
        end
        IO_YIELD: begin
          cpu_gnt = bus.cpu_req;
          io_gnt  = bus.io_req & ~bus.cpu_req;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_d   = state_q;
    burst_d   = burst_q;
    burst_inc = sat_inc(burst_q, BURST_C);
    if (bus.io_req && !io_gnt)
      starve_d = (starve_q >= STARVE_C) ? STARVE_C : starve_q + 4'd1;
    else
      starve_d = 4'd0;
    tag_d.vld = (cpu_gnt & ~bus.cpu_we) | (io_gnt & ~bus.io_we);
    tag_d.own = io_gnt ? OWN_IO : OWN_CPU;

    case (state_q)
      CPU_PRI: begin
        burst_d = 8'd0;
        // The grant that opens a burst counts as its first access
        if (io_gnt && bus.io_lock) begin
          state_d = IO_BURST;
          burst_d = 8'd1;
        end
      end
      IO_BURST: begin
        if (io_gnt) burst_d = burst_inc;
        if (!bus.io_lock || !bus.io_req) begin
          state_d = CPU_PRI;
          burst_d = 8'd0;
        end else if (bus.cpu_req && io_gnt && burst_inc == BURST_C) begin
          // BURST-th I/O grant with the CPU waiting: hand it the next slot
          state_d = IO_YIELD;
          burst_d = 8'd0;
        end
      end
      IO_YIELD: begin
        burst_d = io_gnt ? 8'd1 : 8'd0;
        state_d = bus.io_lock ? IO_BURST : CPU_PRI;
      end
      default: begin
        state_d = CPU_PRI;
        burst_d = 8'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q  <= CPU_PRI;
      starve_q <= 4'd0;
      burst_q  <= 8'd0;
      tag_q    <= '0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
      burst_q  <= burst_d;
      tag_q    <= tag_d;
    end
  end

  // With no grant the address bus parks on the CPU address
  assign maddr  = io_gnt ? bus.io_addr  : bus.cpu_addr;
  assign mwdata = io_gnt ? bus.io_wdata : bus.cpu_wdata;

  assign bus.mem_addr   = maddr;
  assign bus.mem_wdata  = mwdata;
  assign bus.mem_we     = (cpu_gnt & bus.cpu_we) | (io_gnt & bus.io_we);

  assign bus.cpu_gnt    = cpu_gnt;
  assign bus.io_gnt     = io_gnt;
  assign bus.cpu_rvalid = tag_q.vld && (tag_q.own == OWN_CPU);
  assign bus.io_rvalid  = tag_q.vld && (tag_q.own == OWN_IO);
  assign bus.cpu_rdata  = bus.mem_rdata;
  assign bus.io_rdata   = bus.mem_rdata;

endmodule

// File: tb/tb_mix_mem_arbiter.sv
// Directed bench for mix_mem_arbiter with a registered 4096-word memory model.
module tb_mix_mem_arbiter;
  import mix_pkg::*;

  logic clk;
  logic nreset;
  int   checks = 0;
  int   errors = 0;

  mix_mem_arbiter_if #(.AW(12), .DW(31)) bus ();

  mix_mem_arbiter #(.AW(12), .DW(31), .STARVE(4), .BURST(8)) dut (
    .clk    (clk),
    .nreset (nreset),
    .bus    (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Unwritten words read back a known address-derived pattern
  function automatic logic [30:0] init_val(input logic [11:0] a);
    return 31'h122F + 31'(a);
  endfunction

  logic [30:0] mem [4096];
  logic        wr  [4096];
  logic        init_done = 1'b0;

  always @(posedge clk) begin
    if (!init_done) begin
      for (int i = 0; i < 4096; i++) wr[i] <= 1'b0;
      init_done     <= 1'b1;
      bus.mem_rdata <= '0;
    end else begin
      if (bus.mem_we) begin
        mem[bus.mem_addr] <= bus.mem_wdata;
        wr[bus.mem_addr]  <= 1'b1;
      end
      bus.mem_rdata <= wr[bus.mem_addr] ? mem[bus.mem_addr] : init_val(bus.mem_addr);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        eio, ecpu, prev_io, prev_cpu;
    logic [11:0] last_io;

    nreset = 1'b0;
    bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
    bus.io_req  = 1'b0; bus.io_we  = 1'b0; bus.io_addr  = '0; bus.io_wdata  = '0;
    bus.io_lock = 1'b0;

    // Reset holds grants, write strobe and rvalids low
    #2;
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.io_req = 1'b1;
    #1;
    chk("rst_cpu_gnt",    32'(bus.cpu_gnt),    32'd0);
    chk("rst_io_gnt",     32'(bus.io_gnt),     32'd0);
    chk("rst_mem_we",     32'(bus.mem_we),     32'd0);
    chk("rst_cpu_rvalid", 32'(bus.cpu_rvalid), 32'd0);
    chk("rst_io_rvalid",  32'(bus.io_rvalid),  32'd0);
    chk("rst_state",      32'(dut.state_q),    32'(CPU_PRI));
    bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.io_req = 1'b0;
    repeat (2) @(posedge clk);
    #1 nreset = 1'b1;
    tick();

    // CPU-only read of address 5
    bus.cpu_req = 1'b1; bus.cpu_addr = 12'd5;
    @(negedge clk);
    chk("t1_cpu_gnt",  32'(bus.cpu_gnt),  32'd1);
    chk("t1_io_gnt",   32'(bus.io_gnt),   32'd0);
    chk("t1_mem_addr", 32'(bus.mem_addr), 32'd5);
    chk("t1_mem_we",   32'(bus.mem_we),   32'd0);
    tick();
    bus.cpu_req = 1'b0;
    @(negedge clk);
    chk("t1_cpu_rvalid", 32'(bus.cpu_rvalid), 32'd1);
    chk("t1_cpu_rdata",  32'(bus.cpu_rdata),  32'h1234);
    chk("t1_io_rvalid",  32'(bus.io_rvalid),  32'd0);
    tick();
    @(negedge clk);
    chk("t1_rvalid_one", 32'(bus.cpu_rvalid), 32'd0);
    tick();

    // Contention: CPU wins 4 times, I/O takes the 5th slot
    bus.cpu_req = 1'b1; bus.cpu_addr = 12'd7;
    bus.io_req  = 1'b1; bus.io_addr  = 12'd9;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("t2_cpu_gnt", 32'(bus.cpu_gnt), 32'(i != 4));
      chk("t2_io_gnt",  32'(bus.io_gnt),  32'(i == 4));
      chk("t2_excl",    32'(bus.cpu_gnt & bus.io_gnt), 32'd0);
      if (i == 4) chk("t2_starve_sat", 32'(dut.starve_q), 32'd4);
      if (i == 5) begin
        chk("t2_starve_clr", 32'(dut.starve_q),  32'd0);
        chk("t2_io_rvalid",  32'(bus.io_rvalid), 32'd1);
        chk("t2_io_rdata",   32'(bus.io_rdata),  32'(init_val(12'd9)));
      end
      tick();
    end
    bus.cpu_req = 1'b0; bus.io_req = 1'b0;
    tick();

    // Locked burst: 8 io, 1 cpu, 8 io, 1 cpu, 4 io
    bus.io_req = 1'b1; bus.io_lock = 1'b1; bus.io_addr = 12'd100;
    bus.cpu_addr = 12'd20;
    prev_io = 1'b0; prev_cpu = 1'b0; last_io = '0;
    for (int c = 0; c < 23; c++) begin
      if (c == 3) bus.cpu_req = 1'b1;
      if (c == 22) begin
        bus.io_req = 1'b0; bus.io_lock = 1'b0; bus.cpu_req = 1'b0;
      end
      eio  = (c < 22) && (c < 8 || (c >= 9 && c < 17) || c >= 18);
      ecpu = (c == 8) || (c == 17);
      @(negedge clk);
      chk("t3_io_gnt",     32'(bus.io_gnt),     32'(eio));
      chk("t3_cpu_gnt",    32'(bus.cpu_gnt),    32'(ecpu));
      chk("t3_io_rvalid",  32'(bus.io_rvalid),  32'(prev_io));
      chk("t3_cpu_rvalid", 32'(bus.cpu_rvalid), 32'(prev_cpu));
      if (prev_io)  chk("t3_io_rdata",  32'(bus.io_rdata),  32'(init_val(last_io)));
      if (prev_cpu) chk("t3_cpu_rdata", 32'(bus.cpu_rdata), 32'(init_val(12'd20)));
      prev_io  = eio;
      prev_cpu = ecpu;
      tick();
      if (eio) begin
        last_io     = bus.io_addr;
        bus.io_addr = bus.io_addr + 12'd1;
      end
    end
    @(negedge clk);
    chk("t3_end_state", 32'(dut.state_q), 32'(CPU_PRI));
    tick();

    // Burst exit on io_lock drop with a pending CPU request
    bus.io_req = 1'b1; bus.io_lock = 1'b1; bus.io_addr = 12'd300;
    @(negedge clk);
    chk("t4_io_gnt0", 32'(bus.io_gnt), 32'd1);
    tick();
    bus.io_addr = 12'd301; bus.cpu_req = 1'b1;
    @(negedge clk);
    chk("t4_io_gnt1",  32'(bus.io_gnt),  32'd1);
    chk("t4_cpu_gnt1", 32'(bus.cpu_gnt), 32'd0);
    tick();
    bus.io_addr = 12'd302; bus.io_lock = 1'b0;
    @(negedge clk);
    chk("t4_state_burst", 32'(dut.state_q), 32'(IO_BURST));
    tick();
    @(negedge clk);
    chk("t4_state_pri", 32'(dut.state_q), 32'(CPU_PRI));
    chk("t4_cpu_gnt",   32'(bus.cpu_gnt), 32'd1);
    chk("t4_io_gnt",    32'(bus.io_gnt),  32'd0);
    tick();
    bus.cpu_req = 1'b0; bus.io_req = 1'b0;
    tick();

    // I/O write to the top word
    bus.io_req = 1'b1; bus.io_we = 1'b1; bus.io_addr = 12'hFFF; bus.io_wdata = 31'h7FFFFFFF;
    @(negedge clk);
    chk("t5_io_gnt",    32'(bus.io_gnt),    32'd1);
    chk("t5_cpu_gnt",   32'(bus.cpu_gnt),   32'd0);
    chk("t5_mem_we",    32'(bus.mem_we),    32'd1);
    chk("t5_mem_addr",  32'(bus.mem_addr),  32'hFFF);
    chk("t5_mem_wdata", 32'(bus.mem_wdata), 32'h7FFFFFFF);
    tick();
    bus.io_req = 1'b0; bus.io_we = 1'b0;
    @(negedge clk);
    chk("t5_mem_we_off",  32'(bus.mem_we),     32'd0);
    chk("t5_io_rvalid",   32'(bus.io_rvalid),  32'd0);
    chk("t5_cpu_rvalid",  32'(bus.cpu_rvalid), 32'd0);
    chk("t5_mem_written", 32'(mem[4095]),      32'h7FFFFFFF);
    tick();

    // Async reset right after an I/O read grant inside a burst
    bus.io_req = 1'b1; bus.io_lock = 1'b1; bus.io_addr = 12'd200;
    @(negedge clk);
    chk("t6_io_gnt0", 32'(bus.io_gnt), 32'd1);
    tick();
    bus.io_addr = 12'd201;
    @(negedge clk);
    chk("t6_io_gnt1", 32'(bus.io_gnt),  32'd1);
    chk("t6_state",   32'(dut.state_q), 32'(IO_BURST));
    @(posedge clk);
    #2;
    nreset = 1'b0; bus.cpu_req = 1'b1; bus.cpu_we = 1'b1;
    #1;
    chk("t6_rst_cpu_gnt",    32'(bus.cpu_gnt),    32'd0);
    chk("t6_rst_io_gnt",     32'(bus.io_gnt),     32'd0);
    chk("t6_rst_mem_we",     32'(bus.mem_we),     32'd0);
    chk("t6_rst_io_rvalid",  32'(bus.io_rvalid),  32'd0);
    chk("t6_rst_cpu_rvalid", 32'(bus.cpu_rvalid), 32'd0);
    chk("t6_rst_state",      32'(dut.state_q),    32'(CPU_PRI));
    chk("t6_rst_burst",      32'(dut.burst_q),    32'd0);
    #1;
    nreset = 1'b1;
    bus.io_req = 1'b0; bus.io_lock = 1'b0; bus.cpu_req = 1'b0; bus.cpu_we = 1'b0;
    @(negedge clk);
    chk("t6_post_io_rvalid", 32'(bus.io_rvalid), 32'd0);
    chk("t6_post_state",     32'(dut.state_q),   32'(CPU_PRI));
    tick();
    @(negedge clk);
    chk("t6_post_io_rvalid2", 32'(bus.io_rvalid), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
